// File: rtl/udp_port_demux_if.sv
// udp_port_demux_if: IP byte stream into the demux and UDP payload/status out of it
// Ports: ip_data_in/ip_byte_valid/ip_eof/ip_err feed the demux; udp_data_out/udp_byte_valid/
//        udp_chan/udp_eof/udp_err/udp_drop are its outputs. slave = demux side, master = source/sink side.
interface udp_port_demux_if #(
    parameter int CW = 2
);
    logic [7:0]    ip_data_in;
    logic          ip_byte_valid;
    logic          ip_eof;
    logic          ip_err;
    logic [7:0]    udp_data_out;
    logic          udp_byte_valid;
    logic [CW-1:0] udp_chan;
    logic          udp_eof;
    logic          udp_err;
    logic          udp_drop;
    modport master (
        output ip_data_in, ip_byte_valid, ip_eof, ip_err,
        input  udp_data_out, udp_byte_valid, udp_chan, udp_eof, udp_err, udp_drop
    );
    modport slave (
        input  ip_data_in, ip_byte_valid, ip_eof, ip_err,
        output udp_data_out, udp_byte_valid, udp_chan, udp_eof, udp_err, udp_drop
    );
endinterface

// File: rtl/udp_port_demux.sv
// udp_port_demux: parses the UDP header, forwards payload of datagrams whose dest port matches a list entry
// Ports: clk; rst (async, active-high); bus (slave): ip_* byte stream in, udp_* payload and status pulses out;
//        frame_cnt: saturating good-datagram count per channel; drop_cnt: saturating unmatched-datagram count
module udp_port_demux #(
    parameter int                      NUM_PORTS = 4,
    parameter logic [NUM_PORTS*16-1:0] PORT_LIST = {16'h1237, 16'h1236, 16'h1235, 16'h1234},
    parameter int                      CNT_WIDTH = 16,
    parameter bit                      CHK_LEN   = 1'b1,
    localparam int                     CW        = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    udp_port_demux_if.slave                bus,
    output logic [NUM_PORTS*CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0]           drop_cnt
);
    typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;
    state_t               st, st_n;
    logic [2:0]           idx, idx_n;
    logic [15:0]          dport, dport_n, len, len_n, pcnt, pcnt_n;
    logic                 bad, bad_n, hit, lacking;
    logic [CW-1:0]        chan, chan_n, hit_idx;
    logic [7:0]           dout, dout_n;
    logic                 bv, bv_n, eof, eof_n, err, err_n, drop, drop_n;
    logic [CNT_WIDTH-1:0] fcnt [NUM_PORTS];
    logic [CNT_WIDTH-1:0] dcnt;
    // descending scan so the lowest matching index is the one left standing
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--)
            if (dport == PORT_LIST[16*i +: 16]) begin
                hit     = 1'b1;
                hit_idx = CW'(i);
            end
    end
    always_comb begin
        st_n    = st;
        idx_n   = idx;
        dport_n = dport;
        len_n   = len;
        bad_n   = bad;
        chan_n  = chan;
        pcnt_n  = pcnt;
        dout_n  = bus.ip_data_in;
        bv_n    = 1'b0;
        eof_n   = 1'b0;
        err_n   = 1'b0;
        drop_n  = 1'b0;
        if (bus.ip_byte_valid)
            case (st)
                HDR: begin
                    idx_n   = idx + 3'd1;
                    dport_n = idx == 3'd2 ? {bus.ip_data_in, dport[7:0]} :
                              idx == 3'd3 ? {dport[15:8], bus.ip_data_in} : dport;
                    len_n   = idx == 3'd4 ? {bus.ip_data_in, len[7:0]} :
                              idx == 3'd5 ? {len[15:8], bus.ip_data_in} : len;
                    if (idx == 3'd7) begin
                        pcnt_n = '0;
                        bad_n  = len < 16'd8;
                        chan_n = hit && !bad_n ? hit_idx : chan;
                        st_n   = hit && !bad_n ? PAYLOAD : DROP;
                    end
                end
                PAYLOAD: begin
                    // bytes past the UDP length are Ethernet padding when length checking is on
                    bv_n   = !CHK_LEN || pcnt < len - 16'd8;
                    pcnt_n = pcnt + {15'd0, ~&pcnt};
                end
                default: ;
            endcase
        // termination is judged on the state after this cycle's byte, so eof on header byte 7 is a complete header
        lacking = CHK_LEN && pcnt_n < len_n - 16'd8;
        if (bus.ip_err) begin
            bv_n  = 1'b0;
            err_n = 1'b1;
            st_n  = HDR;
            idx_n = '0;
        end else if (bus.ip_eof) begin
            eof_n  = st_n == PAYLOAD && !lacking;
            err_n  = (st_n == PAYLOAD && lacking) || (st_n == DROP && bad_n) || (st_n == HDR && idx_n != 3'd0);
            drop_n = st_n == DROP && !bad_n;
            st_n   = HDR;
            idx_n  = '0;
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            st    <= HDR;
            idx   <= '0;
            dport <= '0;
            len   <= '0;
            pcnt  <= '0;
            bad   <= 1'b0;
            chan  <= '0;
            dout  <= '0;
            bv    <= 1'b0;
            eof   <= 1'b0;
            err   <= 1'b0;
            drop  <= 1'b0;
            dcnt  <= '0;
            for (int i = 0; i < NUM_PORTS; i++)
                fcnt[i] <= '0;
        end else begin
            st    <= st_n;
            idx   <= idx_n;
            dport <= dport_n;
            len   <= len_n;
            pcnt  <= pcnt_n;
            bad   <= bad_n;
            chan  <= chan_n;
            dout  <= dout_n;
            bv    <= bv_n;
            eof   <= eof_n;
            err   <= err_n;
            drop  <= drop_n;
            if (eof_n && !(&fcnt[chan_n]))
                fcnt[chan_n] <= fcnt[chan_n] + CNT_WIDTH'(1);
            if (drop_n && !(&dcnt))
                dcnt <= dcnt + CNT_WIDTH'(1);
        end
    for (genvar i = 0; i < NUM_PORTS; i++)
        assign frame_cnt[CNT_WIDTH*i +: CNT_WIDTH] = fcnt[i];
    assign drop_cnt           = dcnt;
    assign bus.udp_data_out   = dout;
    assign bus.udp_byte_valid = bv;
    assign bus.udp_chan       = chan;
    assign bus.udp_eof        = eof;
    assign bus.udp_err        = err;
    assign bus.udp_drop       = drop;
endmodule

// File: tb/tb_udp_port_demux.sv
// tb_udp_port_demux: randomized + directed datagrams against a datagram-level model, scoreboard-checked
module tb_udp_port_demux;
    localparam int NP = 4;
    localparam logic [NP*16-1:0] PL = {16'h1237, 16'h1236, 16'h1235, 16'h1234};
    typedef struct {logic [7:0] d; logic [1:0] ch; int cyc;} byte_t;
    typedef struct {int kind; logic [1:0] ch; int cyc; int fc; int dc;} ev_t;
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] din = '0;
    logic dv = 1'b0, deof = 1'b0, derr = 1'b0;
    logic [NP*16-1:0] fc0;
    logic [15:0]      dc0;
    logic [NP*2-1:0]  fc1;
    logic [1:0]       dc1;
    int cyc = 0, pass = 0, total = 0, md = 0, nev = 0;
    int mf [NP];
    bit mon_en = 1'b0;
    logic [7:0] dg [$];
    byte_t bq [$];
    ev_t   eq [$];
    byte_t bx;
    ev_t   ex;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    udp_port_demux_if #(.CW(2)) b0 ();
    udp_port_demux_if #(.CW(2)) b1 ();
    assign b0.ip_data_in = din;
    assign b0.ip_byte_valid = dv;
    assign b0.ip_eof = deof;
    assign b0.ip_err = derr;
    assign b1.ip_data_in = din;
    assign b1.ip_byte_valid = dv;
    assign b1.ip_eof = deof;
    assign b1.ip_err = derr;
    udp_port_demux #(.NUM_PORTS(NP), .PORT_LIST(PL), .CNT_WIDTH(16), .CHK_LEN(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(b0), .frame_cnt(fc0), .drop_cnt(dc0));
    udp_port_demux #(.NUM_PORTS(NP), .PORT_LIST(PL), .CNT_WIDTH(2), .CHK_LEN(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .bus(b1), .frame_cnt(fc1), .drop_cnt(dc1));
    function automatic int sat3(input int v);
        return v > 3 ? 3 : v;
    endfunction
    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            dv = 1'b0; deof = 1'b0; derr = 1'b0;
        end
    endtask
    task automatic build(input logic [15:0] dst, input logic [15:0] len, input int n);
        dg.delete();
        dg.push_back(8'($urandom)); dg.push_back(8'($urandom));
        dg.push_back(dst[15:8]);    dg.push_back(dst[7:0]);
        dg.push_back(len[15:8]);    dg.push_back(len[7:0]);
        dg.push_back(8'($urandom)); dg.push_back(8'($urandom));
        for (int j = 0; j < n; j++) dg.push_back(8'($urandom));
    endtask
    // mode: 0 eof on last byte, 1 eof one cycle after, 2 err on last byte, 3 err+eof on last byte
    task automatic send(input int mode, input bit gaps);
        int t, m, lim, kind, fc;
        logic [15:0] dst, len;
        bit ok, ab;
        t = dg.size(); dst = '0; len = '0; m = -1;
        if (t >= 4) dst = {dg[2], dg[3]};
        if (t >= 6) len = {dg[4], dg[5]};
        for (int i = NP - 1; i >= 0; i--) if (dst == PL[16*i +: 16]) m = i;
        ok  = t >= 8 && len >= 16'd8 && m >= 0;
        lim = ok ? int'(len) - 8 : 0;
        ab  = mode >= 2;
        if (ab) kind = 1;
        else if (t == 0) kind = -1;
        else if (t < 8 || len < 16'd8) kind = 1;
        else if (m < 0) kind = 2;
        else kind = (t - 8 < lim) ? 1 : 0;
        fc = 0;
        if (kind == 0) begin mf[m]++; fc = mf[m]; end
        if (kind == 2) md++;
        for (int k = 0; k < t; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) idle(1);
            @(negedge clk);
            din = dg[k]; dv = 1'b1;
            deof = (k == t - 1) && (mode == 0 || mode == 3);
            derr = (k == t - 1) && ab;
            if (k >= 8 && ok && k - 8 < lim && !(ab && k == t - 1))
                bq.push_back('{dg[k], 2'(m), cyc + 1});
            if (k == t - 1 && mode != 1 && kind >= 0)
                eq.push_back('{kind, 2'(m < 0 ? 0 : m), cyc + 1, fc, md});
        end
        if (mode == 1) begin
            if (gaps) idle(1);
            @(negedge clk);
            dv = 1'b0; deof = 1'b1; derr = 1'b0;
            if (kind >= 0) eq.push_back('{kind, 2'(m < 0 ? 0 : m), cyc + 1, fc, md});
        end
    endtask
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (b0.udp_byte_valid) begin
                if (bq.size() == 0) begin
                    total++;
                    $display("FAIL byte_extra: got byte %h, expected no byte", b0.udp_data_out);
                end else begin
                    bx = bq.pop_front();
                    chk("byte_data", b0.udp_data_out, bx.d);
                    chk("byte_chan", b0.udp_chan, bx.ch);
                    chk("byte_cycle", cyc, bx.cyc);
                end
            end
            nev = int'(b0.udp_eof) + int'(b0.udp_err) + int'(b0.udp_drop);
            if (nev > 0) begin
                chk("evt_exclusive", nev, 1);
                if (eq.size() == 0) begin
                    total++;
                    $display("FAIL evt_extra: got eof/err/drop %b%b%b, expected none", b0.udp_eof, b0.udp_err, b0.udp_drop);
                end else begin
                    ex = eq.pop_front();
                    chk("evt_kind", b0.udp_eof ? 0 : b0.udp_err ? 1 : 2, ex.kind);
                    chk("evt_cycle", cyc, ex.cyc);
                    if (ex.kind == 0) begin
                        chk("eof_chan", b0.udp_chan, ex.ch);
                        chk("frame_cnt", fc0[16*ex.ch +: 16], ex.fc);
                        chk("frame_cnt_sat", fc1[2*ex.ch +: 2], sat3(ex.fc));
                    end
                    if (ex.kind == 2) begin
                        chk("drop_cnt", dc0, ex.dc);
                        chk("drop_cnt_sat", dc1, sat3(ex.dc));
                    end
                end
            end
        end
    end
    initial begin
        int sel, mode, t;
        logic [15:0] dst, len;
        for (int i = 0; i < NP; i++) mf[i] = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", b0.udp_byte_valid, 0);
        chk("rst_evts", {b0.udp_eof, b0.udp_err, b0.udp_drop}, 0);
        chk("rst_chan", b0.udp_chan, 0);
        chk("rst_frame_cnt", fc0, 0);
        chk("rst_drop_cnt", dc0, 0);
        rst = 1'b0; mon_en = 1'b1;
        build(16'h1235, 16'h000C, 4);
        dg[8] = 8'hAA; dg[9] = 8'hBB; dg[10] = 8'hCC; dg[11] = 8'hDD;
        send(0, 0);
        build(16'h5555, 16'h000A, 2); send(0, 0);
        build(16'h1234, 16'h000C, 2); send(1, 0);
        build(16'h1234, 16'h000A, 6); send(0, 0);
        build(16'h1236, 16'h0010, 4); send(3, 0);
        build(16'h1236, 16'h000C, 4); send(0, 0);
        build(16'h1235, 16'h0010, 0);
        while (dg.size() > 5) void'(dg.pop_back());
        send(1, 0);
        dg.delete(); send(1, 0);
        build(16'h1234, 16'h0005, 3); send(0, 0);
        build(16'h1234, 16'h0008, 0); send(0, 0);
        idle(2);
        @(negedge clk);
        mon_en = 1'b0;
        build(16'h1234, 16'h0010, 3);
        for (int k = 0; k < dg.size(); k++) begin
            din = dg[k]; dv = 1'b1; deof = 1'b0; derr = 1'b0;
            @(negedge clk);
        end
        @(posedge clk); #1;
        chk("pre_rst_valid", b0.udp_byte_valid, 1);
        rst = 1'b1; #1;
        chk("midrst_valid", b0.udp_byte_valid, 0);
        chk("midrst_data", b0.udp_data_out, 0);
        chk("midrst_evts", {b0.udp_eof, b0.udp_err, b0.udp_drop}, 0);
        chk("midrst_frame_cnt", fc0, 0);
        chk("midrst_frame_cnt_sat", fc1, 0);
        chk("midrst_drop_cnt", dc0, 0);
        @(negedge clk);
        dv = 1'b0; bq.delete(); eq.delete(); md = 0;
        for (int i = 0; i < NP; i++) mf[i] = 0;
        rst = 1'b0; mon_en = 1'b1;
        build(16'h1235, 16'h000C, 4); send(0, 0);
        for (int r = 0; r < 5; r++) begin
            build(16'h1237, 16'h000A, 2); send(0, 0);
        end
        idle(2);
        chk("sat_ch3", fc1[7:6], 3);
        chk("full_ch3", fc0[63:48], mf[3]);
        for (int r = 0; r < 150; r++) begin
            sel = $urandom_range(0, 9);
            t = $urandom_range(0, 3);
            dst = sel < 6 ? PL[16*t +: 16] : 16'($urandom);
            len = $urandom_range(0, 9) == 0 ? 16'($urandom_range(0, 7)) : 16'(8 + $urandom_range(0, 10));
            build(dst, len, $urandom_range(0, 10));
            sel = $urandom_range(0, 9);
            mode = sel < 4 ? 0 : sel < 6 ? 1 : sel == 6 ? 2 : sel == 7 ? 3 : sel == 8 ? 4 : 0;
            if (mode == 4) begin
                t = $urandom_range(1, 7);
                while (dg.size() > t) void'(dg.pop_back());
                mode = $urandom_range(0, 1);
            end
            send(mode, 1'($urandom_range(0, 1)));
        end
        idle(5);
        chk("bytes_outstanding", bq.size(), 0);
        chk("evts_outstanding", eq.size(), 0);
        for (int i = 0; i < NP; i++) begin
            chk("final_frame_cnt", fc0[16*i +: 16], mf[i]);
            chk("final_frame_cnt_sat", fc1[2*i +: 2], sat3(mf[i]));
        end
        chk("final_drop_cnt", dc0, md);
        chk("final_drop_cnt_sat", dc1, sat3(md));
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
